// File: rtl/stencil_window_gen_if.sv
// Stream bundle for the stencil window generator: grid words in, windows out.
// out_last exists only when STENCIL_FRAME_LAST_EN is defined.
interface stencil_window_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [5*DATA_WIDTH-1:0] out_data;
  logic [31:0]             out_counter;
  logic                    out_valid;
  logic                    out_ready;
  logic                    frame_done;
`ifdef STENCIL_FRAME_LAST_EN
  logic                    out_last;
`endif

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_counter,
    output out_valid,
    input  out_ready,
`ifdef STENCIL_FRAME_LAST_EN
    output out_last,
`endif
    output frame_done
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_counter,
    input  out_valid,
    output out_ready,
`ifdef STENCIL_FRAME_LAST_EN
    input  out_last,
`endif
    input  frame_done
  );
endinterface

// File: rtl/stencil_window_gen.sv
// 5-point stencil window producer over a SIZE x SIZE row-major stream.
// STENCIL_FRAME_LAST_EN adds out_last on the final window of a frame.
module stencil_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  stencil_window_gen_if.master bus
);
  localparam int DEPTH = 2 * SIZE + 1;
  localparam logic [31:0] LAST_IN   = 32'(SIZE * SIZE);
  localparam logic [31:0] LAST_OUT  = 32'(SIZE * SIZE + SIZE);
  localparam logic [31:0] FIRST_OUT = 32'(SIZE + 1);

  typedef enum logic [1:0] {
    INGEST,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0]   dl [DEPTH];
  logic [31:0]             cnt;
  logic [31:0]             cnt_nx;
  logic [DATA_WIDTH-1:0]   word;
  logic                    adv;
  logic                    shift;
  logic                    rdy;
  logic                    done_c;
  logic                    vld_q;
  logic                    fd_q;
  logic [5*DATA_WIDTH-1:0] data_q;
  logic [31:0]             ctr_q;

  assign cnt_nx = cnt + 32'd1;
  assign adv    = !vld_q | bus.out_ready;

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    shift    = 1'b0;
    done_c   = 1'b0;
    word     = bus.in_data;
    unique case (state)
      INGEST: begin
        rdy   = adv;
        shift = bus.in_valid & adv;
        if (shift && cnt_nx == LAST_IN)
          state_nx = FLUSH;
      end
      FLUSH: begin
        shift = adv;
        word  = '0;
        if (shift && cnt_nx == LAST_OUT)
          state_nx = DONE;
      end
      DONE: begin
        if (adv) begin
          done_c   = 1'b1;
          state_nx = INGEST;
        end
      end
      default: state_nx = INGEST;
    endcase
  end

  // Delay line keeps its contents across frames; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        dl[k] <= '0;
    end else if (shift) begin
      dl[0] <= word;
      for (int k = 1; k < DEPTH; k++)
        dl[k] <= dl[k-1];
    end
  end

  // Taps are read pre-shift, one slot shallower than their post-shift index.
  logic [DATA_WIDTH-1:0] t_c, t_n, t_s, t_e, t_w;
  assign t_s = word;
  assign t_e = dl[SIZE-2];
  assign t_c = dl[SIZE-1];
  assign t_w = dl[SIZE];
  assign t_n = dl[2*SIZE-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INGEST;
      cnt    <= '0;
      vld_q  <= 1'b0;
      fd_q   <= 1'b0;
      data_q <= '0;
      ctr_q  <= '0;
    end else begin
      state <= state_nx;
      fd_q  <= done_c;
      if (shift)
        cnt <= cnt_nx;
      else if (done_c)
        cnt <= '0;
      if (shift) begin
        data_q <= {t_c, t_n, t_s, t_e, t_w};
        ctr_q  <= cnt_nx;
        vld_q  <= (cnt_nx >= FIRST_OUT);
      end else if (bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

`ifdef STENCIL_FRAME_LAST_EN
  logic last_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_q <= 1'b0;
    else if (shift)
      last_q <= (cnt_nx == LAST_OUT);
  end
  assign bus.out_last = last_q;
`endif

  assign bus.in_ready    = rdy & !rst;
  assign bus.out_valid   = vld_q;
  assign bus.out_data    = data_q;
  assign bus.out_counter = ctr_q;
  assign bus.frame_done  = fd_q;
endmodule

// File: tb/tb_stencil_window_gen.sv
// Directed and seeded-random bench for stencil_window_gen at SIZE=4.
// Expected windows come from a history of every word shifted since reset.
module tb_stencil_window_gen;
  localparam int DW   = 32;
  localparam int SIZE = 4;
  localparam int NW   = SIZE * SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stencil_window_gen_if #(.DATA_WIDTH(DW)) bus ();

  stencil_window_gen #(
    .DATA_WIDTH(DW),
    .SIZE      (SIZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] hist [$];

  task automatic chk(input string tag,
                     input logic [191:0] obs,
                     input logic [191:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] h(input int i);
    if (i < 0 || i >= hist.size())
      return 32'd0;
    return hist[i];
  endfunction

  function automatic logic [159:0] win(input int base, input int c);
    int p;
    p = base + c - 1;
    return {h(p - SIZE), h(p - 2*SIZE), h(p),
            h(p - SIZE + 1), h(p - SIZE - 1)};
  endfunction

  task automatic run_frame(input logic [31:0] vals [NW],
                           input int pv, input int pr,
                           input bit bp_en, input bit dir);
    int idx = 0, nwin = 0, fd = 0, cyc = 0;
    int bp_left = 0, c8 = 0, c16 = 0;
    bit bp_done = 0, early = 0;
    int base;
    logic [159:0] snap_d;
    logic [31:0]  snap_c;
    base = hist.size();
    for (int i = 0; i < NW; i++)
      hist.push_back(vals[i]);
    for (int i = 0; i < SIZE; i++)
      hist.push_back(32'd0);
    while ((nwin < NW || fd == 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bp_en && !bp_done && bp_left == 0 &&
          bus.out_valid && bus.out_counter == 32'd7) begin
        bp_left = 3;
        snap_d  = bus.out_data;
        snap_c  = bus.out_counter;
      end
      if (bp_left > 0)
        bus.out_ready = 1'b0;
      else
        bus.out_ready = ($urandom_range(0, 99) < pr);
      bus.in_valid = (idx < NW) && ($urandom_range(0, 99) < pv);
      bus.in_data  = bus.in_valid ? vals[idx] : $urandom;
      #1;
      if (bus.frame_done)
        fd++;
      if (idx <= SIZE && bus.out_valid)
        early = 1;
      if (bp_left > 0) begin
        chk("bp_data", bus.out_data, snap_d);
        chk("bp_ctr", bus.out_counter, snap_c);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        bp_left--;
        if (bp_left == 0)
          bp_done = 1;
      end
      if (bus.in_valid && bus.in_ready)
        idx++;
      if (bus.out_valid && bus.out_ready) begin
        chk("win_ctr", bus.out_counter, 32'(SIZE + 1 + nwin));
        chk("win_data", bus.out_data, win(base, SIZE + 1 + nwin));
        if (nwin == 0)
          chk("first_center", bus.out_data[159:128], vals[0]);
        if (dir && bus.out_counter == 32'd5)
          chk("dir_c5", bus.out_data,
              {32'd1, 32'd0, 32'd5, 32'd2, 32'd0});
        if (dir && bus.out_counter == 32'd10)
          chk("dir_c10", bus.out_data,
              {32'd6, 32'd2, 32'd10, 32'd7, 32'd5});
        if (dir && bus.out_counter == 32'd20)
          chk("dir_c20", bus.out_data,
              {32'd16, 32'd12, 32'd0, 32'd0, 32'd15});
`ifdef STENCIL_FRAME_LAST_EN
        chk("out_last", bus.out_last,
            bus.out_counter == 32'(NW + SIZE));
`endif
        if (bus.out_counter == 32'd8)
          c8 = cyc;
        if (bus.out_counter == 32'd16)
          c16 = cyc;
        nwin++;
      end
    end
    chk("frame_windows", nwin, NW);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (bus.frame_done)
        fd++;
    end
    chk("frame_done_once", fd, 1);
    chk("no_early_valid", early, 1'b0);
    if (bp_en) begin
      chk("bp_seen", bp_done, 1'b1);
      chk("bp_resume_rate", c16 - c8, 8);
    end
  endtask

  logic [31:0] v [NW];

  initial begin
    int acc;
    int cyc;
    void'($urandom(32'd1234));
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 160'd0);
    chk("rst_out_counter", bus.out_counter, 32'd0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
`ifdef STENCIL_FRAME_LAST_EN
    chk("rst_out_last", bus.out_last, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NW; i++)
      v[i] = 32'(i + 1);
    run_frame(v, 100, 100, 1'b0, 1'b1);

    for (int i = 0; i < NW; i++)
      v[i] = 32'(100 + 7 * i);
    run_frame(v, 100, 100, 1'b1, 1'b0);

    for (int i = 0; i < NW; i++)
      v[i] = $urandom;
    run_frame(v, 50, 50, 1'b0, 1'b0);

    acc = 0;
    cyc = 0;
    while (acc < 9 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'(200 + acc);
      #1;
      if (bus.in_ready)
        acc++;
    end
    chk("partial_accepts", acc, 9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_data", bus.out_data, 160'd0);
    chk("mid_rst_out_counter", bus.out_counter, 32'd0);
    chk("mid_rst_frame_done", bus.frame_done, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hist.delete();

    for (int i = 0; i < NW; i++)
      v[i] = 32'(300 + 3 * i);
    run_frame(v, 100, 100, 1'b0, 1'b0);

    for (int i = 0; i < NW; i++)
      v[i] = $urandom;
    run_frame(v, 50, 50, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
